// File: rtl/ysyx_24110006_rf_wb_scheduler.sv
// Register-file write-port scheduler: round-robin EXU/LSU writeback arbiter, busy scoreboard
// and decode hazard detection. Define RF_BYPASS_EN to forward the in-flight write to decode.
module ysyx_24110006_rf_wb_scheduler #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic [1:0]            i_wb_valid,
    input  logic [ADDR_WIDTH-1:0] i_wb_rd0,
    input  logic [DATA_WIDTH-1:0] i_wb_data0,
    input  logic [ADDR_WIDTH-1:0] i_wb_rd1,
    input  logic [DATA_WIDTH-1:0] i_wb_data1,
    output logic [1:0]            o_wb_ready,
    input  logic                  i_issue_valid,
    input  logic [ADDR_WIDTH-1:0] i_issue_rd,
    output logic                  o_issue_ready,
    input  logic [ADDR_WIDTH-1:0] i_raddr1,
    input  logic [ADDR_WIDTH-1:0] i_raddr2,
    output logic                  o_raw_stall,
    output logic                  o_byp1,
    output logic                  o_byp2,
    output logic                  o_wen,
    output logic [ADDR_WIDTH-1:0] o_waddr,
    output logic [DATA_WIDTH-1:0] o_wdata
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0]       busy_q, busy_d;
    logic                  rr_q, rr_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            grant;
    logic                  issue_ready;

    // rr_q = 0 prefers R0 when both requesters are valid
    always_comb begin
        grant[0] = i_wb_valid[0] & (~i_wb_valid[1] | ~rr_q);
        grant[1] = i_wb_valid[1] & (~i_wb_valid[0] |  rr_q);
    end

    assign o_wb_ready    = grant;
    assign issue_ready   = (i_issue_rd == '0) | ~busy_q[i_issue_rd];
    assign o_issue_ready = issue_ready;

    always_comb begin
        rr_d    = rr_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        if (&i_wb_valid)
            rr_d = ~rr_q;
        if (grant[0]) begin
            wen_d   = (i_wb_rd0 != '0);
            waddr_d = i_wb_rd0;
            wdata_d = i_wb_data0;
        end else if (grant[1]) begin
            wen_d   = (i_wb_rd1 != '0);
            waddr_d = i_wb_rd1;
            wdata_d = i_wb_data1;
        end
        // Clear lands as the regfile commits; issue to a busy reg is blocked, so no overlap
        if (wen_q)
            busy_d[waddr_q] = 1'b0;
        if (i_issue_valid && issue_ready && (i_issue_rd != '0))
            busy_d[i_issue_rd] = 1'b1;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            busy_q  <= '0;
            rr_q    <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            busy_q  <= busy_d;
            rr_q    <= rr_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_wen   = wen_q;
    assign o_waddr = waddr_q;
    assign o_wdata = wdata_q;

`ifdef RF_BYPASS_EN
    logic byp1, byp2;
    assign byp1 = (i_raddr1 != '0) & wen_q & (waddr_q == i_raddr1);
    assign byp2 = (i_raddr2 != '0) & wen_q & (waddr_q == i_raddr2);
    assign o_byp1 = byp1;
    assign o_byp2 = byp2;
    // A source busy only because of the write now on the port is forwarded instead
    assign o_raw_stall = ((i_raddr1 != '0) & busy_q[i_raddr1] & ~byp1) |
                         ((i_raddr2 != '0) & busy_q[i_raddr2] & ~byp2);
`else
    assign o_byp1 = 1'b0;
    assign o_byp2 = 1'b0;
    assign o_raw_stall = ((i_raddr1 != '0) & busy_q[i_raddr1]) |
                         ((i_raddr2 != '0) & busy_q[i_raddr2]);
`endif

endmodule

// File: tb/tb_ysyx_24110006_rf_wb_scheduler.sv
// Scoreboard bench for ysyx_24110006_rf_wb_scheduler: a cycle model predicts grants, busy
// state and hazards; granted writes are queued and matched against the registered write port.
module tb_ysyx_24110006_rf_wb_scheduler;

    typedef struct {
        logic        wen;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  v;
    logic [4:0]  rd0, rd1, ird, ra1, ra2;
    logic [31:0] d0, d1;
    logic        iv;
    logic [1:0]  o_wb_ready;
    logic        o_issue_ready, o_raw_stall, o_byp1, o_byp2, o_wen;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata;

    ysyx_24110006_rf_wb_scheduler #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_wb_valid   (v),
        .i_wb_rd0     (rd0),
        .i_wb_data0   (d0),
        .i_wb_rd1     (rd1),
        .i_wb_data1   (d1),
        .o_wb_ready   (o_wb_ready),
        .i_issue_valid(iv),
        .i_issue_rd   (ird),
        .o_issue_ready(o_issue_ready),
        .i_raddr1     (ra1),
        .i_raddr2     (ra2),
        .o_raw_stall  (o_raw_stall),
        .o_byp1       (o_byp1),
        .o_byp2       (o_byp2),
        .o_wen        (o_wen),
        .o_waddr      (o_waddr),
        .o_wdata      (o_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [31:0] m_busy;
    logic        m_rr;
    logic        m_wen;
    logic [4:0]  m_waddr;
    wr_t         q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle();
        v = 2'b00; rd0 = 5'd0; rd1 = 5'd0; d0 = 32'd0; d1 = 32'd0;
        iv = 1'b0; ird = 5'd0; ra1 = 5'd0; ra2 = 5'd0;
    endtask

    task automatic model_reset();
        m_busy = 32'd0; m_rr = 1'b0; m_wen = 1'b0; m_waddr = 5'd0;
        q.delete();
    endtask

    // One clock: check combinational outputs, predict, clock, check the write port
    task automatic cyc();
        logic g0, g1, ir, eb1, eb2, st;
        wr_t  e;
        #1;
        g0 = v[0] & (~v[1] | ~m_rr);
        g1 = v[1] & (~v[0] | m_rr);
        ir = (ird == 5'd0) | ~m_busy[ird];
`ifdef RF_BYPASS_EN
        eb1 = (ra1 != 5'd0) & m_wen & (m_waddr == ra1);
        eb2 = (ra2 != 5'd0) & m_wen & (m_waddr == ra2);
`else
        eb1 = 1'b0;
        eb2 = 1'b0;
`endif
        st = ((ra1 != 5'd0) & m_busy[ra1] & ~eb1) | ((ra2 != 5'd0) & m_busy[ra2] & ~eb2);
        chk("wb_ready", {62'd0, o_wb_ready}, {62'd0, g1, g0});
        chk("issue_ready", {63'd0, o_issue_ready}, {63'd0, ir});
        chk("raw_stall", {63'd0, o_raw_stall}, {63'd0, st});
        chk("byp1", {63'd0, o_byp1}, {63'd0, eb1});
        chk("byp2", {63'd0, o_byp2}, {63'd0, eb2});
        if (g0) q.push_back('{wen: (rd0 != 5'd0), addr: rd0, data: d0});
        if (g1) q.push_back('{wen: (rd1 != 5'd0), addr: rd1, data: d1});
        @(posedge clk);
        if (m_wen) m_busy[m_waddr] = 1'b0;
        if (iv && ir && ird != 5'd0) m_busy[ird] = 1'b1;
        if (v == 2'b11) m_rr = ~m_rr;
        m_wen = 1'b0;
        if (g0) begin m_wen = (rd0 != 5'd0); m_waddr = rd0; end
        else if (g1) begin m_wen = (rd1 != 5'd0); m_waddr = rd1; end
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("wen", {63'd0, o_wen}, {63'd0, e.wen});
            if (e.wen) begin
                chk("waddr", {59'd0, o_waddr}, {59'd0, e.addr});
                chk("wdata", {32'd0, o_wdata}, {32'd0, e.data});
            end
        end else begin
            chk("wen_idle", {63'd0, o_wen}, 64'd0);
        end
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 1'b0;
        #12;
        chk("rst_wen", {63'd0, o_wen}, 64'd0);
        chk("rst_waddr", {59'd0, o_waddr}, 64'd0);
        chk("rst_wdata", {32'd0, o_wdata}, 64'd0);
        chk("rst_ready", {63'd0, o_issue_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Both requesters every cycle: strict alternation 3,4,3,4,...
        v = 2'b11; rd0 = 5'd3; d0 = 32'h1111_0003; rd1 = 5'd4; d1 = 32'h2222_0004;
        for (int i = 0; i < 6; i++) cyc();
        idle();
        cyc();

        // WAW: rd 7 issued, re-issue blocked until R1 commits rd 7
        iv = 1'b1; ird = 5'd7;
        cyc();
        cyc();
        cyc();
        v = 2'b10; rd1 = 5'd7; d1 = 32'h0000_0777;
        cyc();
        v = 2'b00;
        cyc();
        chk("waw_ready_back", {63'd0, o_issue_ready}, 64'd1);
        cyc();
        idle();
        cyc();

        // RAW on x9 resolved by an R0 write of 0xDEADBEEF
        iv = 1'b1; ird = 5'd9;
        cyc();
        iv = 1'b0; ird = 5'd0; ra1 = 5'd9;
        cyc();
        v = 2'b01; rd0 = 5'd9; d0 = 32'hDEAD_BEEF;
        cyc();
        v = 2'b00;
        cyc();
        cyc();
        idle();

        // Write to x0: granted, no regfile write; rs2 = x0 never stalls
        iv = 1'b1; ird = 5'd11;
        cyc();
        iv = 1'b0; ird = 5'd11; ra2 = 5'd0; ra1 = 5'd11;
        v = 2'b10; rd1 = 5'd0; d1 = 32'h0000_1234;
        cyc();
        v = 2'b00;
        cyc();
        idle();

        // Issue rd 2 in the same cycle the write of rd 6 commits
        iv = 1'b1; ird = 5'd6;
        cyc();
        iv = 1'b0;
        v = 2'b01; rd0 = 5'd6; d0 = 32'h0000_0066;
        cyc();
        v = 2'b00; iv = 1'b1; ird = 5'd2;
        cyc();
        iv = 1'b0; ird = 5'd6; ra1 = 5'd2; ra2 = 5'd6;
        cyc();
        idle();
        // Drain x11 so only the reset test owns the busy state
        v = 2'b01; rd0 = 5'd11; d0 = 32'h0000_00BB;
        cyc();
        v = 2'b01; rd0 = 5'd2; d0 = 32'h0000_0022;
        cyc();
        idle();
        cyc();

        // Async reset in the middle of a write to busy x5, pointer left on R1
        iv = 1'b1; ird = 5'd5;
        cyc();
        iv = 1'b0; ird = 5'd5;
        v = 2'b11; rd0 = 5'd5; d0 = 32'h0000_0555; rd1 = 5'd5; d1 = 32'h0000_0AAA;
        cyc();
        chk("pre_rst_wen", {63'd0, o_wen}, 64'd1);
        v = 2'b00; ra1 = 5'd5;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_wen", {63'd0, o_wen}, 64'd0);
        chk("async_stall", {63'd0, o_raw_stall}, 64'd0);
        chk("async_issue_ready", {63'd0, o_issue_ready}, 64'd1);
        chk("async_waddr", {59'd0, o_waddr}, 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        v = 2'b11; rd0 = 5'd0; rd1 = 5'd0;
        cyc();
        idle();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
